bp_be_stride_prefetcher: RTL



---
 rtl/bp_be_stride_prefetcher.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bp_be_stride_prefetcher.sv
// bp_be_stride_prefetcher: tracks confirmed load/store strides by PC and turns each one into
// a bounded burst of block-aligned D$ prefetch requests over valid/ready.
module bp_be_stride_prefetcher #(
  parameter int vaddr_width_p = 39,
  parameter int stride_width_p = 8,
  parameter int streams_p = 4,
  parameter int depth_p = 4,
  parameter int block_offset_width_p = 6
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]  striding_pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_i,
  output logic                      busy_o
);
  localparam int idx_w = $clog2(streams_p);
  localparam int rem_w = $clog2(depth_p + 1);
  localparam int blk_w = vaddr_width_p - block_offset_width_p;
  typedef logic [idx_w-1:0] idx_t;

  function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  // Reset asserts asynchronously but releases only after two clean edges.
  logic [1:0] rst_sync_r;
  logic       rst_n;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) rst_sync_r <= '0;
    else rst_sync_r <= {rst_sync_r[0], 1'b1};
  assign rst_n = rst_sync_r[1];

  logic [streams_p-1:0]      tbl_v;
  logic [vaddr_width_p-1:0]  tbl_pc     [streams_p];
  logic [vaddr_width_p-1:0]  tbl_next   [streams_p];
  logic [stride_width_p-1:0] tbl_stride [streams_p];
  logic [rem_w-1:0]          tbl_rem    [streams_p];
  logic [blk_w-1:0]          tbl_blk    [streams_p];
  idx_t                      victim_ptr, last_grant;

  logic [streams_p-1:0] hit, cand;
  logic                 hit_any, inv_any, gnt_any;
  idx_t                 hit_idx, inv_idx, gnt_idx;
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      hit[i]  = tbl_v[i] & (tbl_pc[i] == striding_pc_i);
      cand[i] = tbl_v[i] & (tbl_rem[i] != '0);
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (!tbl_v[i]) begin
        inv_any = 1'b1;
        inv_idx = idx_t'(i);
      end
    end
    gnt_any = 1'b0;
    gnt_idx = '0;
    // Descending scan so the nearest entry after last_grant wins; last_grant itself is last.
    for (int k = streams_p; k >= 1; k--)
      if (cand[idx_t'(last_grant + idx_t'(k))]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_t'(last_grant + idx_t'(k));
      end
  end

  logic                     do_conf, do_inv, touch, fire, issue;
  idx_t                     wr_idx, touch_idx;
  logic [blk_w-1:0]         gnt_blk;
  logic [vaddr_width_p-1:0] gnt_next;
  assign wr_idx    = hit_any ? hit_idx : inv_any ? inv_idx : victim_ptr;
  assign do_conf   = confirm_discovery_i;
  assign do_inv    = start_discovery_i & ~confirm_discovery_i & hit_any;
  assign touch     = do_conf | do_inv;
  assign touch_idx = do_conf ? wr_idx : hit_idx;
  assign fire      = gnt_any & (~pf_v_o | pf_ready_i) & ~flush_i & ~(touch & (touch_idx == gnt_idx));
  assign gnt_blk   = tbl_next[gnt_idx][vaddr_width_p-1:block_offset_width_p];
  assign gnt_next  = tbl_next[gnt_idx] + sext(tbl_stride[gnt_idx]);
  assign issue     = fire & (gnt_blk != tbl_blk[gnt_idx]);

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      tbl_v      <= '0;
      victim_ptr <= '0;
      last_grant <= idx_t'(streams_p - 1);
      for (int i = 0; i < streams_p; i++) begin
        tbl_pc[i]     <= '0;
        tbl_next[i]   <= '0;
        tbl_stride[i] <= '0;
        tbl_rem[i]    <= '0;
        tbl_blk[i]    <= '0;
      end
    end else if (flush_i) tbl_v <= '0;
    else begin
      if (fire) begin
        tbl_next[gnt_idx] <= gnt_next;
        tbl_rem[gnt_idx]  <= tbl_rem[gnt_idx] - rem_w'(1);
        if (issue) tbl_blk[gnt_idx] <= gnt_blk;
        last_grant <= gnt_idx;
      end
      if (do_conf) begin
        tbl_v[wr_idx]      <= 1'b1;
        tbl_pc[wr_idx]     <= striding_pc_i;
        tbl_next[wr_idx]   <= eff_addr_i + sext(stride_i);
        tbl_stride[wr_idx] <= stride_i;
        tbl_rem[wr_idx]    <= rem_w'(depth_p);
        tbl_blk[wr_idx]    <= eff_addr_i[vaddr_width_p-1:block_offset_width_p];
        if (!hit_any && !inv_any) victim_ptr <= victim_ptr + idx_t'(1);
      end
      if (do_inv) tbl_v[hit_idx] <= 1'b0;
    end

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      pf_v_o    <= 1'b0;
      pf_addr_o <= '0;
    end else if (flush_i) pf_v_o <= 1'b0;
    else if (issue) begin
      pf_v_o    <= 1'b1;
      pf_addr_o <= {gnt_blk, {block_offset_width_p{1'b0}}};
    end else if (pf_ready_i) pf_v_o <= 1'b0;

  assign busy_o = pf_v_o | (|cand);
endmodule
